imem_loadable: RTL and testbench
================================

Name: imem_loadable

Overview:
- Parametrised instruction memory for the single-cycle MIPS core.
- Replaces hard-coded initial contents with a byte-serial program-load port: a valid/ready handshake fills memory big-endian, word by word.
- After loading, serves instruction fetches through a registered read port with 1-cycle latency.
- Sits between the boot/debug loader and the core's fetch stage; holds the core in reset-equivalent state (busy) while loading.

Parameters:
- ADDR_W, 8, log2 of depth in 32-bit words (depth = 2**ADDR_W)
- DATA_W, 32, instruction width; must be a multiple of 8
- NOP_WORD, 32'h00000000, value returned on out-of-range or misaligned fetch

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  reset, synchronous, active-low
- ld_valid  in  1  loader byte valid
- ld_ready  out  1  block accepts a byte this cycle
- ld_byte  in  8  program byte, MSB-first within each word
- ld_last  in  1  qualifies the final byte of the image (sampled with ld_valid)
- ld_start  in  1  one-cycle pulse: enter LOAD from RUN/IDLE
- fetch_en  in  1  fetch request
- pc  in  32  byte address of the fetch
- instr  out  DATA_W  fetched instruction, registered
- instr_valid  out  1  instr holds the result of the previous cycle's fetch
- busy  out  1  high in LOAD
- addr_err  out  1  registered; previous fetch was out of range or misaligned
- ld_overflow  out  1  sticky; image exceeded depth

Behaviour:
- Reset values: instr=NOP_WORD, instr_valid=0, addr_err=0, ld_ready=0, busy=0, ld_overflow=0. Byte counter and word pointer are 0; state is IDLE. Memory contents are not cleared.
- States:
  - IDLE: waits for ld_start; goes to RUN on the first fetch_en.
  - LOAD: on entry, clears the word pointer, byte counter and ld_overflow.
  - RUN: normal operation; ld_start re-enters LOAD.
- LOAD handshake:
  - ld_ready=1 throughout LOAD.
  - A byte transfers when ld_valid && ld_ready.
  - Bytes shift into a DATA_W assembly register, MSB-first.
  - When the byte counter reaches DATA_W/8-1, the word is written at the word pointer the same cycle, and the pointer increments.
- ld_last:
  - With a partial word, the remaining low bytes are zero-padded and that word is written.
  - State goes to RUN on the next cycle; ld_ready drops the same cycle as the last transfer.
- Overflow:
  - A write attempted at pointer == depth sets ld_overflow and discards the write.
  - Loading continues to consume bytes until ld_last. The pointer saturates and does not wrap.
- Fetch:
  - In RUN with fetch_en=1, the index is pc[ADDR_W+1:2].
  - instr and instr_valid are updated next cycle.
  - If pc[1:0]!=0 or pc[31:ADDR_W+2]!=0: instr=NOP_WORD and addr_err=1.
- fetch_en=0 in RUN: instr holds its value, instr_valid=0.
- Fetch in IDLE: treated as RUN (the contents are whatever was preloaded).
- Fetch in LOAD: ignored. instr_valid=0, instr=NOP_WORD.
- Simultaneous ld_start and fetch_en in RUN: ld_start wins and the fetch is dropped.
- Reset mid-LOAD: returns to IDLE. A partial word is lost; words already written are retained.

Optional Feature:
- IMEM_PARITY_EN:
  - Each word stores an extra even-parity bit, computed at write.
  - On fetch, parity is checked and the result registered on the added output parity_err (1-bit, reset 0, valid alongside instr_valid).
  - The instruction is still delivered.
- Without the macro: no parity storage and no parity_err port.

Decomposition:
- Shared package mips_pkg holds:
  - state enum imem_state_t {IDLE, LOAD, RUN}
  - NOP_WORD default
  - BYTES_PER_WORD constant
- Sub-module imem_byte_packer: byte counter, shift/assembly register, zero-pad on last, and word_valid/word_data output.
- The top level holds the FSM, the memory array and the fetch register.

Test Plan:
- Load 8 bytes 20 10 00 0A 20 11 00 14 with ld_last on the 8th, then fetch pc=0 and pc=4:
  - next-cycle instr = 2010000A, then 20110014; instr_valid=1; addr_err=0.
- Partial load of 5 bytes AC 12 00 00 FF (last), then fetch pc=4 → instr = FF000000.
- ld_valid toggling every other cycle across 12 bytes → 3 words written correctly; ld_ready stays 1 until the last transfer.
- Misaligned pc=2 → instr=NOP_WORD, addr_err=1. Out-of-range pc=32'h400 (ADDR_W=8) → same.
- Stream 4*256+4 bytes with ADDR_W=8:
  - ld_overflow=1; word 255 is intact; word 0 is unchanged (no wrap).
- Pulse reset_n low for one cycle after 2 bytes of a load:
  - state returns to IDLE and busy=0.
  - A subsequent fetch returns previously stored words.
- With IMEM_PARITY_EN: force a bit flip in a stored word → parity_err=1 with instr_valid.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction memory.
// Defines the loader/fetch state encoding and word geometry.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } imem_state_t;

  localparam logic [31:0] NOP_WORD_DEF   = 32'h0000_0000;
  localparam int          BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_byte_packer.sv
// Byte-serial to word packer, MSB-first within each word.
// A final partial word is zero-padded in its low bytes.
module imem_byte_packer
  import mips_pkg::*;
#(
  parameter int DATA_W = BYTES_PER_WORD * 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  input  logic              in_last,
  output logic              word_valid,
  output logic [DATA_W-1:0] word_data
);

  localparam int BPW = DATA_W / 8;
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(BPW - 1);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic [DATA_W-1:0] shifted;
  int unsigned       pad;

  // Shift in bytes, emit full words or padded last word.
  always_comb begin
    shifted    = (asm_q << 8) | DATA_W'(in_byte);
    pad        = 8 * (BPW - 1 - int'(cnt_q));
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    word_valid = 1'b0;
    word_data  = shifted;
    if (clear) begin
      cnt_d = '0;
      asm_d = '0;
    end else if (in_valid) begin
      asm_d = shifted;
      if (cnt_q == CNT_TOP) begin
        word_valid = 1'b1;
        cnt_d      = '0;
      end else if (in_last) begin
        word_valid = 1'b1;
        word_data  = shifted << pad;
        cnt_d      = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Counter and assembly register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
    end
  end

endmodule

// File: rtl/imem_loadable.sv
// Loadable instruction memory: byte-serial load, registered fetch.
// Define IMEM_PARITY_EN to add per-word even parity and parity_err.
module imem_loadable
  import mips_pkg::*;
#(
  parameter int               ADDR_W   = 8,
  parameter int               DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  input  logic              ld_start,
  input  logic              fetch_en,
  input  logic [31:0]       pc,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              busy,
  output logic              addr_err,
  output logic              ld_overflow
`ifdef IMEM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  imem_state_t       state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              ival_q, ival_d;
  logic              aerr_q, aerr_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              we;
  logic [ADDR_W-1:0] widx;
  logic [ADDR_W-1:0] ridx;
  logic              pc_bad;
  logic              xfer;
  logic              load_go;
  logic              word_valid;
  logic [DATA_W-1:0] word_data;

`ifdef IMEM_PARITY_EN
  logic              par_q [DEPTH];
  logic              perr_q, perr_d;
  assign parity_err = perr_q;
`endif

  assign ld_ready    = (state_q == LOAD);
  assign busy        = (state_q == LOAD);
  assign xfer        = ld_valid && ld_ready;
  assign load_go     = ld_start && (state_q != LOAD);
  assign instr       = instr_q;
  assign instr_valid = ival_q;
  assign addr_err    = aerr_q;
  assign ld_overflow = ovf_q;
  assign ridx        = pc[ADDR_W+1:2];
  assign widx        = ptr_q[ADDR_W-1:0];
  assign pc_bad      = (pc[1:0] != 2'b00) || ((pc >> (ADDR_W + 2)) != 32'd0);

  imem_byte_packer #(.DATA_W(DATA_W)) u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (load_go),
    .in_valid   (xfer),
    .in_byte    (ld_byte),
    .in_last    (ld_last),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  // FSM next state, write pointer, and fetch result.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ovf_d   = ovf_q;
    instr_d = instr_q;
    ival_d  = 1'b0;
    aerr_d  = 1'b0;
    we      = 1'b0;
`ifdef IMEM_PARITY_EN
    perr_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE, RUN: begin
        if (load_go) begin
          state_d = LOAD;
          ptr_d   = '0;
          ovf_d   = 1'b0;
        end else if (fetch_en) begin
          state_d = RUN;
          ival_d  = 1'b1;
          if (pc_bad) begin
            instr_d = NOP_WORD;
            aerr_d  = 1'b1;
          end else begin
            instr_d = mem_q[ridx];
`ifdef IMEM_PARITY_EN
            perr_d  = ^{mem_q[ridx], par_q[ridx]};
`endif
          end
        end
      end
      LOAD: begin
        instr_d = NOP_WORD;
        if (word_valid) begin
          if (ptr_q == FULL) begin
            ovf_d = 1'b1;
          end else begin
            we    = 1'b1;
            ptr_d = ptr_q + 1'b1;
          end
        end
        if (xfer && ld_last) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and fetch registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
      instr_q <= NOP_WORD;
      ival_q  <= 1'b0;
      aerr_q  <= 1'b0;
`ifdef IMEM_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
      instr_q <= instr_d;
      ival_q  <= ival_d;
      aerr_q  <= aerr_d;
`ifdef IMEM_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  // Memory array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[widx] <= word_data;
`ifdef IMEM_PARITY_EN
      par_q[widx] <= ^word_data;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loadable.sv
// Self-checking bench for imem_loadable.
// Fetch results go through a scoreboard queue.
module tb_imem_loadable;

  logic        clk;
  logic        reset_n;
  logic        ld_valid;
  logic        ld_ready;
  logic [7:0]  ld_byte;
  logic        ld_last;
  logic        ld_start;
  logic        fetch_en;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        busy;
  logic        addr_err;
  logic        ld_overflow;
`ifdef IMEM_PARITY_EN
  logic        parity_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic        par;
    string       nm;
  } exp_t;

  exp_t sb_q[$];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } fvec_t;

  fvec_t tbl[8];

  imem_loadable #(.ADDR_W(8), .DATA_W(32), .NOP_WORD(32'h0)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_byte     (ld_byte),
    .ld_last     (ld_last),
    .ld_start    (ld_start),
    .fetch_en    (fetch_en),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .busy        (busy),
    .addr_err    (addr_err),
    .ld_overflow (ld_overflow)
`ifdef IMEM_PARITY_EN
    ,
    .parity_err  (parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: compare each valid fetch result with the queued one.
  always @(negedge clk) begin
    if (reset_n && instr_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_valid", {31'd0, instr_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk({e.nm, "_instr"}, instr, e.instr);
        chk({e.nm, "_err"}, {31'd0, addr_err}, {31'd0, e.err});
`ifdef IMEM_PARITY_EN
        chk({e.nm, "_par"}, {31'd0, parity_err}, {31'd0, e.par});
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_load();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    chk("load_busy", {31'd0, busy}, 32'd1);
    chk("load_ovf_clr", {31'd0, ld_overflow}, 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last,
                           input int gap);
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    if (!ld_ready) chk("ld_ready_hi", {31'd0, ld_ready}, 32'd1);
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    for (int i = 0; i < gap; i++) begin
      if (!ld_ready) chk("ld_ready_gap", {31'd0, ld_ready}, 32'd1);
      tick();
    end
    if (last) begin
      chk("after_last_ready", {31'd0, ld_ready}, 32'd0);
      chk("after_last_busy", {31'd0, busy}, 32'd0);
    end
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] ei,
                       input logic ee, input logic ep, input string nm);
    exp_t e;
    e.instr = ei;
    e.err   = ee;
    e.par   = ep;
    e.nm    = nm;
    sb_q.push_back(e);
    fetch_en = 1'b1;
    pc       = a;
    tick();
    fetch_en = 1'b0;
  endtask

  function automatic logic [7:0] ovf_byte(input int k);
    return 8'((k * 7) + (k >> 8));
  endfunction

  function automatic logic [31:0] ovf_word(input int w);
    return {ovf_byte(4*w), ovf_byte(4*w+1), ovf_byte(4*w+2), ovf_byte(4*w+3)};
  endfunction

  initial begin
    logic [7:0] img1 [8];
    logic [7:0] img3 [12];
    img1 = '{8'h20, 8'h10, 8'h00, 8'h0A, 8'h20, 8'h11, 8'h00, 8'h14};
    img3 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
             8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    tbl[0] = '{32'h0000_0000, 32'h1122_3344, 1'b0};
    tbl[1] = '{32'h0000_0004, 32'h5566_7788, 1'b0};
    tbl[2] = '{32'h0000_0008, 32'h99AA_BBCC, 1'b0};
    tbl[3] = '{32'h0000_0002, 32'h0000_0000, 1'b1};
    tbl[4] = '{32'h0000_0400, 32'h0000_0000, 1'b1};
    tbl[5] = '{32'h0000_0003, 32'h0000_0000, 1'b1};
    tbl[6] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b1};
    tbl[7] = '{32'h0000_03FC, 32'h0000_0000, 1'b1};
    // tbl[7] is in range; its expected value is filled after the overflow load.

    reset_n  = 1'b0;
    ld_valid = 1'b0;
    ld_byte  = 8'h00;
    ld_last  = 1'b0;
    ld_start = 1'b0;
    fetch_en = 1'b0;
    pc       = 32'h0;
    tick();
    tick();
    reset_n = 1'b1;
    chk("rst_instr", instr, 32'h0);
    chk("rst_ivalid", {31'd0, instr_valid}, 32'd0);
    chk("rst_aerr", {31'd0, addr_err}, 32'd0);
    chk("rst_ready", {31'd0, ld_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, ld_overflow}, 32'd0);

    // Two-word image.
    start_load();
    for (int i = 0; i < 8; i++) send_byte(img1[i], i == 7, 0);
    fetch(32'h0, 32'h2010_000A, 1'b0, 1'b0, "img1_w0");
    fetch(32'h4, 32'h2011_0014, 1'b0, 1'b0, "img1_w1");
    tick();

    // Partial last word is zero padded.
    start_load();
    send_byte(8'hAC, 1'b0, 0);
    send_byte(8'h12, 1'b0, 0);
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'hFF, 1'b1, 0);
    fetch(32'h0, 32'hAC12_0000, 1'b0, 1'b0, "part_w0");
    fetch(32'h4, 32'hFF00_0000, 1'b0, 1'b0, "part_w1");
    tick();

    // Gapped valid across three words.
    start_load();
    for (int i = 0; i < 12; i++) send_byte(img3[i], i == 11, (i == 11) ? 0 : 1);
    for (int i = 0; i < 7; i++)
      fetch(tbl[i].pc, tbl[i].instr, tbl[i].err, 1'b0, $sformatf("tbl%0d", i));
    tick();

    // Fetch during LOAD is ignored; reset mid-load keeps stored words.
    start_load();
    send_byte(8'hDE, 1'b0, 0);
    fetch_en = 1'b1;
    pc       = 32'h0;
    ld_valid = 1'b1;
    ld_byte  = 8'hAD;
    tick();
    fetch_en = 1'b0;
    ld_valid = 1'b0;
    chk("load_fetch_ivalid", {31'd0, instr_valid}, 32'd0);
    chk("load_fetch_instr", instr, 32'h0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ready", {31'd0, ld_ready}, 32'd0);
    fetch(32'h0, 32'h1122_3344, 1'b0, 1'b0, "midrst_w0");
    fetch(32'h8, 32'h99AA_BBCC, 1'b0, 1'b0, "midrst_w2");
    tick();

    // Overflow: 257 words into a 256-word memory.
    start_load();
    for (int k = 0; k < 4*256+4; k++) send_byte(ovf_byte(k), k == 4*256+3, 0);
    chk("ovf_set", {31'd0, ld_overflow}, 32'd1);
    tbl[7].instr = ovf_word(255);
    tbl[7].err   = 1'b0;
    fetch(tbl[7].pc, tbl[7].instr, tbl[7].err, 1'b0, "ovf_w255");
    fetch(32'h0, ovf_word(0), 1'b0, 1'b0, "ovf_w0");
    tick();

    // ld_start wins over a simultaneous fetch; re-entry clears overflow.
    ld_start = 1'b1;
    fetch_en = 1'b1;
    pc       = 32'h4;
    tick();
    ld_start = 1'b0;
    fetch_en = 1'b0;
    chk("start_wins_ivalid", {31'd0, instr_valid}, 32'd0);
    chk("start_wins_busy", {31'd0, busy}, 32'd1);
    chk("start_wins_ovf", {31'd0, ld_overflow}, 32'd0);
    send_byte(8'h5A, 1'b1, 0);
    fetch(32'h0, 32'h5A00_0000, 1'b0, 1'b0, "single_byte");
    fetch(32'h4, ovf_word(1), 1'b0, 1'b0, "kept_w1");
    tick();

`ifdef IMEM_PARITY_EN
    dut.mem_q[2] = dut.mem_q[2] ^ 32'h0000_0100;
    fetch(32'h8, ovf_word(2) ^ 32'h0000_0100, 1'b0, 1'b1, "par_flip");
    fetch(32'hC, ovf_word(3), 1'b0, 1'b0, "par_ok");
    tick();
`endif

    tick();
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
